// File: rtl/pb_fb_rr_arbiter.sv
// N-port frontend bus arbiter: one outstanding A->B transaction, fixed priority or round-robin.
// Define NCPU_FB_ARB_WDT_EN to compile in the hung-transaction watchdog (TMO/DRAIN states).
module pb_fb_rr_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RR_EN      = 0,
    parameter int WDT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       fb_s_AVALID,
    output logic [N_PORTS-1:0]       fb_s_AREADY,
    input  logic [N_PORTS*AW-1:0]    fb_s_AADDR,
    input  logic [N_PORTS*DW-1:0]    fb_s_ADATA,
    input  logic [N_PORTS*DW/8-1:0]  fb_s_AWMSK,
    input  logic [N_PORTS*2-1:0]     fb_s_AEXC,
    output logic [N_PORTS-1:0]       fb_s_BVALID,
    input  logic [N_PORTS-1:0]       fb_s_BREADY,
    output logic [DW-1:0]            fb_s_BDATA,
    output logic [1:0]               fb_s_BEXC,
    output logic                     fb_mbus_AVALID,
    input  logic                     fb_mbus_AREADY,
    output logic [AW-1:0]            fb_mbus_AADDR,
    output logic [DW-1:0]            fb_mbus_ADATA,
    output logic [DW/8-1:0]          fb_mbus_AWMSK,
    output logic [1:0]               fb_mbus_AEXC,
    input  logic                     fb_mbus_BVALID,
    output logic                     fb_mbus_BREADY,
    input  logic [DW-1:0]            fb_mbus_BDATA,
    input  logic [1:0]               fb_mbus_BEXC
);

    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CYC   = 2'd1;
`ifdef NCPU_FB_ARB_WDT_EN
    localparam logic [1:0] S_TMO   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
`endif

    logic [1:0]    state, state_nxt;
    logic [GW-1:0] grant, grant_nxt;
    logic [GW-1:0] rr_last, rr_last_nxt;
    logic [GW-1:0] arb_base, arb_win;
    logic          a_done, a_done_nxt;
    logic          any_req, in_cyc, a_hs, b_hs;

    // Fixed priority scans from port 0; round-robin scans from base+1 and wraps.
    function automatic logic [GW-1:0] arb_pick(input logic [N_PORTS-1:0] req,
                                               input logic [GW-1:0]      base);
        logic [GW-1:0] pick;
        logic          hit;
        int            p;
        pick = '0;
        hit  = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            if (RR_EN != 0)
                p = (int'(base) + k) % N_PORTS;
            else
                p = k - 1;
            if (!hit && req[p]) begin
                pick = GW'(p);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req  = |fb_s_AVALID;
    assign in_cyc   = (state == S_CYC);
    // Re-arbitration on a B handshake uses the finishing grant as base, so it ranks last.
    assign arb_base = in_cyc ? grant : rr_last;
    assign arb_win  = arb_pick(fb_s_AVALID, arb_base);
    assign a_hs     = in_cyc & ~a_done & fb_s_AVALID[grant] & fb_mbus_AREADY;
    assign b_hs     = in_cyc &  a_done & fb_mbus_BVALID & fb_s_BREADY[grant];

`ifdef NCPU_FB_ARB_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES + 1);

    logic [CW-1:0] wdt_cnt;
    logic          late_seen;
    logic          grant_load, wdt_tick, wdt_expire;

    assign grant_load = any_req & ((state == S_IDLE) | b_hs);
    assign wdt_tick   = in_cyc & a_done & ~fb_mbus_BVALID;
    assign wdt_expire = wdt_tick & (wdt_cnt == CW'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt   <= '0;
            late_seen <= 1'b0;
        end else begin
            if (grant_load)
                wdt_cnt <= '0;
            else if (wdt_tick)
                wdt_cnt <= wdt_cnt + CW'(1);

            if (grant_load)
                late_seen <= 1'b0;
            else if (state == S_TMO && fb_mbus_BVALID)
                late_seen <= 1'b1;
        end
    end
`endif

    // Output routing: everything is quiet outside CYC except the watchdog response paths.
    always_comb begin
        // NOTE: every output gets a default before the case-specific writes, so no latches are inferred.
        fb_s_AREADY    = '0;
        fb_s_BVALID    = '0;
        fb_s_BDATA     = '0;
        fb_s_BEXC      = '0;
        fb_mbus_AVALID = 1'b0;
        fb_mbus_AADDR  = '0;
        fb_mbus_ADATA  = '0;
        fb_mbus_AWMSK  = '0;
        fb_mbus_AEXC   = '0;
        fb_mbus_BREADY = 1'b0;
        if (in_cyc) begin
            fb_mbus_AVALID     = fb_s_AVALID[grant] & ~a_done;
            fb_s_AREADY[grant] = fb_mbus_AREADY & ~a_done;
            fb_mbus_AADDR      = fb_s_AADDR[int'(grant)*AW +: AW];
            fb_mbus_ADATA      = fb_s_ADATA[int'(grant)*DW +: DW];
            fb_mbus_AWMSK      = fb_s_AWMSK[int'(grant)*(DW/8) +: DW/8];
            fb_mbus_AEXC       = fb_s_AEXC[int'(grant)*2 +: 2];
            fb_s_BVALID[grant] = fb_mbus_BVALID & a_done;
            fb_s_BDATA         = fb_mbus_BDATA;
            fb_s_BEXC          = fb_mbus_BEXC;
            fb_mbus_BREADY     = fb_s_BREADY[grant];
        end
`ifdef NCPU_FB_ARB_WDT_EN
        else if (state == S_TMO) begin
            fb_s_BVALID[grant] = 1'b1;
            fb_s_BEXC          = 2'b11;
            fb_mbus_BREADY     = 1'b1;
        end else if (state == S_DRAIN) begin
            fb_mbus_BREADY     = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        a_done_nxt  = a_done;
        rr_last_nxt = rr_last;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    grant_nxt = arb_win;
                    state_nxt = S_CYC;
                end
            end
            S_CYC: begin
                if (a_hs)
                    a_done_nxt = 1'b1;
                if (b_hs) begin
                    a_done_nxt  = 1'b0;
                    rr_last_nxt = grant;
                    if (any_req)
                        grant_nxt = arb_win;
                    else
                        state_nxt = S_IDLE;
                end
`ifdef NCPU_FB_ARB_WDT_EN
                else if (wdt_expire) begin
                    a_done_nxt = 1'b0;
                    state_nxt  = S_TMO;
                end
`endif
            end
`ifdef NCPU_FB_ARB_WDT_EN
            S_TMO: begin
                if (fb_s_BREADY[grant])
                    state_nxt = (late_seen | fb_mbus_BVALID) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (fb_mbus_BVALID)
                    state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            grant   <= '0;
            a_done  <= 1'b0;
            rr_last <= GW'(N_PORTS - 1);
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
            state   <= state_nxt;
            grant   <= grant_nxt;
            a_done  <= a_done_nxt;
            rr_last <= rr_last_nxt;
        end
    end

endmodule

// File: tb/tb_pb_fb_rr_arbiter.sv
// Directed bench: instance 0 is fixed priority, instance 1 round-robin; both N_PORTS=3, WDT_CYCLES=8.
module tb_pb_fb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [2:0]  s_avalid [2];
    logic [2:0]  s_aready [2];
    logic [2:0]  s_bvalid [2];
    logic [2:0]  s_bready [2];
    logic [31:0] s_bdata  [2];
    logic [1:0]  s_bexc   [2];
    logic [95:0] s_aaddr;
    logic [95:0] s_adata;
    logic [11:0] s_awmsk;
    logic [5:0]  s_aexc;

    logic        m_avalid [2];
    logic        m_aready [2];
    logic [31:0] m_aaddr  [2];
    logic [31:0] m_adata  [2];
    logic [3:0]  m_awmsk  [2];
    logic [1:0]  m_aexc   [2];
    logic        m_bvalid [2];
    logic        m_bready [2];
    logic [31:0] m_bdata  [2];
    logic [1:0]  m_bexc   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pb_fb_rr_arbiter #(.N_PORTS(3), .AW(32), .DW(32), .RR_EN(0), .WDT_CYCLES(8)) u_fp (
        .clk(clk), .rst(rst),
        .fb_s_AVALID(s_avalid[0]), .fb_s_AREADY(s_aready[0]),
        .fb_s_AADDR(s_aaddr), .fb_s_ADATA(s_adata), .fb_s_AWMSK(s_awmsk), .fb_s_AEXC(s_aexc),
        .fb_s_BVALID(s_bvalid[0]), .fb_s_BREADY(s_bready[0]),
        .fb_s_BDATA(s_bdata[0]), .fb_s_BEXC(s_bexc[0]),
        .fb_mbus_AVALID(m_avalid[0]), .fb_mbus_AREADY(m_aready[0]),
        .fb_mbus_AADDR(m_aaddr[0]), .fb_mbus_ADATA(m_adata[0]),
        .fb_mbus_AWMSK(m_awmsk[0]), .fb_mbus_AEXC(m_aexc[0]),
        .fb_mbus_BVALID(m_bvalid[0]), .fb_mbus_BREADY(m_bready[0]),
        .fb_mbus_BDATA(m_bdata[0]), .fb_mbus_BEXC(m_bexc[0])
    );

    pb_fb_rr_arbiter #(.N_PORTS(3), .AW(32), .DW(32), .RR_EN(1), .WDT_CYCLES(8)) u_rr (
        .clk(clk), .rst(rst),
        .fb_s_AVALID(s_avalid[1]), .fb_s_AREADY(s_aready[1]),
        .fb_s_AADDR(s_aaddr), .fb_s_ADATA(s_adata), .fb_s_AWMSK(s_awmsk), .fb_s_AEXC(s_aexc),
        .fb_s_BVALID(s_bvalid[1]), .fb_s_BREADY(s_bready[1]),
        .fb_s_BDATA(s_bdata[1]), .fb_s_BEXC(s_bexc[1]),
        .fb_mbus_AVALID(m_avalid[1]), .fb_mbus_AREADY(m_aready[1]),
        .fb_mbus_AADDR(m_aaddr[1]), .fb_mbus_ADATA(m_adata[1]),
        .fb_mbus_AWMSK(m_awmsk[1]), .fb_mbus_AEXC(m_aexc[1]),
        .fb_mbus_BVALID(m_bvalid[1]), .fb_mbus_BREADY(m_bready[1]),
        .fb_mbus_BDATA(m_bdata[1]), .fb_mbus_BEXC(m_bexc[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on DUT d, starting in CYC with a_done=0 and the M-bus always ready.
    task automatic run_txn(input int d, input int p, input logic last);
        logic [2:0] oh;
        oh = 3'b001 << p;
        #1;
        check($sformatf("d%0d p%0d aready", d, p), 32'(s_aready[d]), 32'(oh));
        check($sformatf("d%0d p%0d mbus_avalid", d, p), 32'(m_avalid[d]), 32'd1);
        check($sformatf("d%0d p%0d aaddr", d, p), m_aaddr[d], 32'h100 * (p + 1));
        check($sformatf("d%0d p%0d aexc", d, p), 32'(m_aexc[d]), 32'(p + 1));
        tick();
        #1;
        check($sformatf("d%0d p%0d aready after A", d, p), 32'(s_aready[d]), 32'd0);
        check($sformatf("d%0d p%0d mbus_avalid after A", d, p), 32'(m_avalid[d]), 32'd0);
        m_bvalid[d] = 1'b1;
        m_bdata[d]  = 32'hB000 + p;
        m_bexc[d]   = 2'b01;
        if (last)
            s_avalid[d] = 3'b000;
        #1;
        check($sformatf("d%0d p%0d bvalid", d, p), 32'(s_bvalid[d]), 32'(oh));
        check($sformatf("d%0d p%0d bdata", d, p), s_bdata[d], 32'hB000 + p);
        tick();
        m_bvalid[d] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        s_aaddr = {32'h300, 32'h200, 32'h100};
        s_adata = {32'hD3, 32'hD2, 32'hD1};
        s_awmsk = 12'hF0F;
        s_aexc  = {2'd3, 2'd2, 2'd1};
        for (int d = 0; d < 2; d++) begin
            s_avalid[d] = 3'b000;
            s_bready[d] = 3'b111;
            m_aready[d] = 1'b1;
            m_bvalid[d] = 1'b0;
            m_bdata[d]  = 32'h0;
            m_bexc[d]   = 2'b00;
        end
        #12;
        rst = 1'b0;
        tick();

        // Reset state and registered grant: requests seen in IDLE are not yet routed.
        s_avalid[0] = 3'b111;
        s_avalid[1] = 3'b111;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d idle aready", d), 32'(s_aready[d]), 32'd0);
            check($sformatf("d%0d idle mbus_avalid", d), 32'(m_avalid[d]), 32'd0);
            check($sformatf("d%0d idle mbus_bready", d), 32'(m_bready[d]), 32'd0);
            check($sformatf("d%0d idle bvalid", d), 32'(s_bvalid[d]), 32'd0);
        end
        tick();

        // Fixed priority on u_fp and round-robin on u_rr run side by side.
        fork
            begin
                run_txn(0, 0, 1'b0);
                run_txn(0, 0, 1'b0);
                run_txn(0, 0, 1'b1);
            end
            begin
                run_txn(1, 0, 1'b0);
                run_txn(1, 1, 1'b0);
                run_txn(1, 2, 1'b0);
                run_txn(1, 0, 1'b1);
            end
        join
        #1;
        check("fp back to idle aready", 32'(s_aready[0]), 32'd0);
        check("rr back to idle aready", 32'(s_aready[1]), 32'd0);

        // Single outstanding transaction and early-B rejection on port 1.
        s_avalid[0] = 3'b010;
        m_aready[0] = 1'b0;
        tick();
        m_bvalid[0] = 1'b1;
        #1;
        check("early B not forwarded", 32'(s_bvalid[0]), 32'd0);
        check("p1 mbus_avalid", 32'(m_avalid[0]), 32'd1);
        check("p1 aready while mbus busy", 32'(s_aready[0]), 32'd0);
        m_bvalid[0] = 1'b0;
        m_aready[0] = 1'b1;
        #1;
        check("p1 aready", 32'(s_aready[0]), 32'b010);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("p1 held aready %0d", i), 32'(s_aready[0]), 32'd0);
            check($sformatf("p1 held mbus_avalid %0d", i), 32'(m_avalid[0]), 32'd0);
            tick();
        end
        m_bvalid[0] = 1'b1;
        #1;
        check("p1 bvalid", 32'(s_bvalid[0]), 32'b010);
        tick();
        m_bvalid[0] = 1'b0;
        #1;
        check("p1 back-to-back aready", 32'(s_aready[0]), 32'b010);
        tick();

        // Reset mid-CYC with a_done=1 and a response on the M-bus.
        m_bvalid[0] = 1'b1;
        m_bdata[0]  = 32'hCAFE;
        #1;
        check("pre-reset bvalid", 32'(s_bvalid[0]), 32'b010);
        rst = 1'b1;
        #1;
        check("reset bvalid", 32'(s_bvalid[0]), 32'd0);
        check("reset aready", 32'(s_aready[0]), 32'd0);
        check("reset mbus_avalid", 32'(m_avalid[0]), 32'd0);
        check("reset mbus_bready", 32'(m_bready[0]), 32'd0);
        check("reset bdata", s_bdata[0], 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset idle mbus_avalid", 32'(m_avalid[0]), 32'd0);
        s_avalid[0] = 3'b000;
        m_bvalid[0] = 1'b0;
        tick();

`ifdef NCPU_FB_ARB_WDT_EN
        // Timeout: M-bus never answers, master holds off BREADY, late response drained.
        s_bready[0] = 3'b000;
        m_bdata[0]  = 32'hDEAD;
        s_avalid[0] = 3'b001;
        tick();
        tick();
        s_avalid[0] = 3'b000;
        repeat (7) tick();
        #1;
        check("wdt before expiry bvalid", 32'(s_bvalid[0]), 32'd0);
        tick();
        #1;
        check("wdt tmo bvalid", 32'(s_bvalid[0]), 32'b001);
        check("wdt tmo bexc", 32'(s_bexc[0]), 32'd3);
        check("wdt tmo bdata", s_bdata[0], 32'd0);
        check("wdt tmo mbus_bready", 32'(m_bready[0]), 32'd1);
        s_bready[0] = 3'b111;
        tick();
        #1;
        check("drain bvalid", 32'(s_bvalid[0]), 32'd0);
        check("drain mbus_bready", 32'(m_bready[0]), 32'd1);
        m_bvalid[0] = 1'b1;
        tick();
        m_bvalid[0] = 1'b0;
        #1;
        check("after drain mbus_bready", 32'(m_bready[0]), 32'd0);

        // Real response in the expiry cycle wins over the timeout.
        s_avalid[0] = 3'b001;
        tick();
        tick();
        s_avalid[0] = 3'b000;
        repeat (7) tick();
        m_bvalid[0] = 1'b1;
        m_bexc[0]   = 2'b01;
        m_bdata[0]  = 32'h55;
        #1;
        check("expiry real bvalid", 32'(s_bvalid[0]), 32'b001);
        check("expiry real bexc", 32'(s_bexc[0]), 32'd1);
        check("expiry real bdata", s_bdata[0], 32'h55);
        tick();
        m_bvalid[0] = 1'b0;
        tick();
        #1;
        check("no tmo after real B", 32'(s_bvalid[0]), 32'd0);
        check("idle after real B mbus_bready", 32'(m_bready[0]), 32'd0);
`else
        // Without the watchdog a hung transaction waits indefinitely.
        s_avalid[0] = 3'b001;
        tick();
        tick();
        s_avalid[0] = 3'b000;
        repeat (20) tick();
        #1;
        check("hang bvalid", 32'(s_bvalid[0]), 32'd0);
        check("hang mbus_bready", 32'(m_bready[0]), 32'd1);
        m_bvalid[0] = 1'b1;
        m_bexc[0]   = 2'b10;
        #1;
        check("hang late bvalid", 32'(s_bvalid[0]), 32'b001);
        check("hang late bexc", 32'(s_bexc[0]), 32'd2);
        tick();
        m_bvalid[0] = 1'b0;
        #1;
        check("hang end mbus_bready", 32'(m_bready[0]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pb_fb_rr_arbiter.md
# pb_fb_rr_arbiter

Parametrised N-port frontend bus arbiter between the core's frontend masters (I-bus, D-bus, and additional agents such as a page-walker or debug port) and the single frontend M-bus. It grants one master at a time for a complete A→B transaction and selects either fixed priority or round-robin. It allows at most one outstanding transaction and supports back-to-back re-arbitration on the B handshake. An optional watchdog can terminate a hung transaction with an error response.

## Interface
Parameters:
- `N_PORTS`, 2: number of masters, 2..8; port 0 has the highest fixed priority (D-bus).
- `AW`, 32: address width.
- `DW`, 32: data width; `DW/8` write-mask bits.
- `RR_EN`, 0: 0 selects fixed priority; 1 selects round-robin.
- `WDT_CYCLES`, 255: watchdog limit in cycles, ≥2. Used only with the watchdog macro.

Ports. Per-master signals are packed; port i occupies slice i.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fb_s_AVALID` in N: A-request valid.
- `fb_s_AREADY` out N: A-request accepted.
- `fb_s_AADDR` in N*AW: address.
- `fb_s_ADATA` in N*DW: write data.
- `fb_s_AWMSK` in N*DW/8: write mask; all zeros means read.
- `fb_s_AEXC` in N*2: A exception tag.
- `fb_s_BVALID` out N: response valid.
- `fb_s_BREADY` in N: response accepted.
- `fb_s_BDATA` out DW: response data, broadcast to all ports.
- `fb_s_BEXC` out 2: response exception, broadcast to all ports.
- `fb_mbus_A*` and `fb_mbus_B*`: single-port mirror of the above; directions are reversed relative to the `fb_s_*` ports.

## Operation
- State register values: IDLE, CYC, TMO, DRAIN. TMO and DRAIN are reachable only with the watchdog.
- Registers:
  - `grant`: index of the granted port.
  - `a_done`: the A handshake of the current grant is complete.
  - `rr_last`: last granted index.
- Arbitration function:
  - Input is the vector of `fb_s_AVALID`.
  - Fixed priority: the lowest asserted index wins.
  - Round-robin: the search starts at `rr_last+1` and wraps modulo N_PORTS.
- IDLE:
  - If any AVALID is asserted, latch the winner into `grant` and go to CYC.
  - Otherwise stay in IDLE.
- CYC, A channel:
  - Only the granted port is routed: `fb_mbus_AVALID = AVALID[grant] & ~a_done` and `AREADY[grant] = fb_mbus_AREADY & ~a_done`.
  - All other AREADY bits are 0.
  - `fb_mbus_AADDR`, `ADATA`, `AWMSK` and `AEXC` are driven from slice `grant`.
  - On the A handshake, set `a_done`. No further A request is accepted until the B handshake.
- CYC, B channel:
  - `BVALID[grant] = fb_mbus_BVALID`; all other BVALID bits are 0.
  - `fb_mbus_BREADY = BREADY[grant]`.
- B handshake in CYC:
  - Clear `a_done` and set `rr_last` to `grant`.
  - If any AVALID is asserted in the same cycle, re-arbitrate: load the new winner and stay in CYC. Otherwise go to IDLE.
  - The requester that just finished competes normally. With RR_EN=1 it has the lowest priority.
- A B response that arrives before `a_done` is set is a protocol violation. It is ignored: BVALID is not forwarded.
- The granted master must hold AVALID until its A handshake. If it drops AVALID first, the grant persists; no timeout applies unless the watchdog is enabled.

## Timing
- Reset values:
  - State IDLE, `grant` 0, `a_done` 0, `rr_last` N_PORTS-1 (so port 0 wins the first round-robin).
  - Watchdog counter 0.
  - All `fb_s_AREADY`, `fb_s_BVALID`, `fb_mbus_AVALID` and `fb_mbus_BREADY` are 0 whenever state is IDLE.
- Latency:
  - Grant is registered: a request seen in IDLE at edge k can handshake on the M-bus no earlier than cycle k+1.
  - The A and B paths are combinational pass-through with no added latency.
- Back-to-back: the next transaction's A can handshake in the cycle after the previous B handshake.
- Reset asserted mid-transaction returns the block to IDLE asynchronously. An in-flight M-bus response is lost; resetting the M-bus is the system's responsibility.

## Configuration
- Macro `NCPU_FB_ARB_WDT_EN`: compiles in the watchdog.
- Counter operation:
  - The counter clears on every grant.
  - It increments each CYC cycle with `a_done=1` and `fb_mbus_BVALID=0`.
  - When it reaches WDT_CYCLES, the block goes to TMO.
- TMO:
  - `BVALID[grant]=1`, `BEXC=2'b11`, `BDATA=0`.
  - `fb_mbus_BREADY=1`, so a late M-bus response is absorbed silently.
  - On the master's BREADY: if the M-bus response was already absorbed, go to IDLE; otherwise go to DRAIN.
- DRAIN:
  - `fb_mbus_BREADY=1`; all master B and A signals are 0.
  - On `fb_mbus_BVALID`, go to IDLE.
- Priority: a real M-bus BVALID in the expiry cycle wins over the timeout.
- Without the macro: no counter is built, TMO and DRAIN do not exist, and a hang persists indefinitely.

## Test plan
- Fixed priority (N=3, RR_EN=0): ports 0, 1 and 2 assert together → grants in order 0, 0, 0 while port 0 keeps requesting, and port 2 is starved. Each B handshake is followed by the next A handshake one cycle later.
- Round-robin (N=3, RR_EN=1), all three ports requesting continuously: grant order 0, 1, 2, 0. `fb_mbus_AADDR` equals the granted slice (0x100, 0x200, 0x300).
- Single outstanding transaction: port 1 re-asserts AVALID after its A handshake and before B → `AREADY[1]` stays 0 until the B handshake.
- Reset mid-CYC (assert `rst` while `a_done=1`) → all outputs drop to 0 asynchronously, and state returns to IDLE.
- Watchdog enabled (`NCPU_FB_ARB_WDT_EN`, WDT_CYCLES=8), M-bus never responds → on the 8th wait cycle `BVALID[grant]=1` with BEXC=2'b11. A late `fb_mbus_BVALID` in DRAIN is absorbed, then IDLE.
- Watchdog enabled, M-bus BVALID arrives in the expiry cycle → the real response is delivered with its own BEXC and no TMO occurs.
